// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 exception/interrupt controller, evaluated on the
// M-stage instruction. Holds SR, Cause, EPC, PRId and a Count/Compare timer.
// Decides each cycle whether to take an interrupt or exception, and drives
// the pipeline flush request and the redirect target.
//
// Ports
//   clk      : system clock, all state on the rising edge
//   rst      : synchronous reset, active low
//   A1       : mfc0 read register number  -> DOut (combinational)
//   A2/DIn/we: mtc0 write port
//   pc, bd   : M-stage PC and branch-delay-slot flag
//   exc_code : M-stage exception code, 0 = none
//   hw_int   : level-sensitive external interrupt lines
//   eret     : M-stage instruction is eret
//   req      : flush and redirect this cycle
//   exc_pc   : redirect target (handler or return address)
//   exl      : current SR.EXL
module cp0_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h2023_0701
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        we,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic [31:0] DOut,
  output logic        req,
  output logic [31:0] exc_pc,
  output logic        exl
);

  localparam logic [4:0] R_COUNT   = 5'd9;
  localparam logic [4:0] R_COMPARE = 5'd11;
  localparam logic [4:0] R_SR      = 5'd12;
  localparam logic [4:0] R_CAUSE   = 5'd13;
  localparam logic [4:0] R_EPC     = 5'd14;
  localparam logic [4:0] R_PRID    = 5'd15;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q, epc_d;
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic        ti_q, ti_d;

  logic [5:0]  ip_live;
  logic        int_req;
  logic        exc_req;

  // The timer shares interrupt line 5 with the external source.
  assign ip_live = {hw_int[5] | ti_q, hw_int[4:0]};
  assign int_req = ie_q & ~exl_q & (|(im_q & ip_live));
  assign exc_req = (exc_code != 5'd0) & ~exl_q;
  assign req     = int_req | exc_req;
  assign exl     = exl_q;

  // Bypass a same-cycle mtc0 EPC so an eret right behind it returns correctly.
  always_comb begin
    if (req)                    exc_pc = HANDLER_PC;
    else if (we && A2 == R_EPC) exc_pc = DIn;
    else                        exc_pc = epc_q;
  end

  always_comb begin
    case (A1)
      R_COUNT:   DOut = count_q;
      R_COMPARE: DOut = compare_q;
      R_SR:      DOut = {16'b0, im_q, 8'b0, exl_q, ie_q};
      R_CAUSE:   DOut = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};
      R_EPC:     DOut = epc_q;
      R_PRID:    DOut = PRID;
      default:   DOut = 32'b0;
    endcase
  end

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    epc_d     = epc_q;
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exc_d     = exc_q;
    ip_d      = ip_live;
    ti_d      = ti_q | ((count_q == compare_q) && (compare_q != 32'd0));

    if (req) begin
      // Taking the trap discards any same-cycle mtc0 and eret.
      exl_d = 1'b1;
      bd_d  = bd;
      exc_d = int_req ? 5'd0 : exc_code;
      epc_d = bd ? (pc - 32'd4) : pc;
    end else begin
      if (we) begin
        case (A2)
          R_SR: begin
            im_d  = DIn[15:10];
            exl_d = DIn[1];
            ie_d  = DIn[0];
          end
          R_EPC:     epc_d = DIn;
          R_COUNT:   count_d = DIn;
          R_COMPARE: begin
            compare_d = DIn;
            ti_d      = 1'b0;
          end
          default: ;
        endcase
      end
      // eret takes precedence over an SR write to EXL in the same cycle.
      if (eret) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= 32'b0;
      compare_q <= 32'b0;
      epc_q     <= 32'b0;
      im_q      <= 6'b0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= 6'b0;
      exc_q     <= 5'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      epc_q     <= epc_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exc_q     <= exc_d;
      ti_q      <= ti_d;
    end
  end

endmodule
